// File: rtl/btn_pkg.sv
// Shared button-scheduler types and button-index constants for cmdId consumers.
package btn_pkg;

    typedef enum logic [1:0] {IDLE, PRESENT, LOCKOUT, HOLD} state_t;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_scheduler_if.sv
// Command handshake between the button scheduler and the sort/display engine.
interface button_scheduler_if #(
    parameter int NUM_BTNS = 5
);
    localparam int ID_W = btn_pkg::id_w(NUM_BTNS);

    logic            cmdValid;
    logic            cmdReady;
    logic [ID_W-1:0] cmdId;

    modport master (output cmdValid, output cmdId, input cmdReady);
    modport slave  (input cmdValid, input cmdId, output cmdReady);
endinterface

// File: rtl/btn_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous button levels.
module btn_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/button_scheduler.sv
// Turns synchronised button presses into one prioritised command each, with a
// shared lockout counter and optional auto-repeat while the button is held.
module button_scheduler
    import btn_pkg::*;
#(
    parameter int NUM_BTNS      = 5,
    parameter int LOCKOUT_COUNT = 20000000,
    parameter int REPEAT_COUNT  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btn,
    button_scheduler_if.master  cmd,
    output logic                busy,
    output logic                cmdDropped
);
    localparam int          ID_W      = id_w(NUM_BTNS);
    localparam logic [31:0] LOCK_LAST = 32'(LOCKOUT_COUNT - 1);
    localparam logic [31:0] REP_LAST  = (REPEAT_COUNT > 0) ? 32'(REPEAT_COUNT - 1) : 32'd0;

    logic [NUM_BTNS-1:0] w_sync;
    logic [NUM_BTNS-1:0] r_prev;
    logic [NUM_BTNS-1:0] w_others;
    logic [NUM_BTNS-1:0] w_rise;
    state_t              r_state, w_next;
    logic [31:0]         r_cnt, w_cnt_next;
    logic [ID_W-1:0]     r_id, w_id_next, w_prio;
    logic                r_dropped;

    btn_sync #(.WIDTH(NUM_BTNS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (btn),
        .o_q   (w_sync)
    );

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        w_prio = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (w_sync[i]) w_prio = ID_W'(i);
        end
    end

    always_comb begin
        w_others = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            w_others[i] = (ID_W'(i) != r_id);
        end
    end

    assign w_rise = w_sync & ~r_prev & w_others;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_id_next  = r_id;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (|w_sync) begin
                    w_next    = PRESENT;
                    w_id_next = w_prio;
                end
            end
            PRESENT: begin
                if (cmd.cmdReady) begin
                    w_next     = LOCKOUT;
                    w_cnt_next = '0;
                end
            end
            LOCKOUT: begin
                if (r_cnt == LOCK_LAST) begin
                    w_next     = HOLD;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            HOLD: begin
                if (!w_sync[r_id]) begin
                    w_next     = IDLE;
                    w_cnt_next = '0;
                end else if (REPEAT_COUNT > 0) begin
                    if (r_cnt == REP_LAST) begin
                        w_next     = PRESENT;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            r_prev    <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_id      <= w_id_next;
            r_prev    <= w_sync;
            // Rising edges seen in IDLE are consumed by arbitration, not dropped.
            r_dropped <= (r_state != IDLE) && (|w_rise);
        end
    end

    assign cmd.cmdValid = (r_state == PRESENT);
    assign cmd.cmdId    = r_id;
    assign busy         = (r_state != IDLE);
    assign cmdDropped   = r_dropped;
endmodule

// File: tb/tb_button_scheduler.sv
// Directed bench: single press, backpressure, priority, drop, auto-repeat, async reset.
module tb_button_scheduler;
    logic       clk;
    logic       reset;
    logic [4:0] btn;
    logic       busy, cmdDropped;
    logic       busy0, cmdDropped0;

    button_scheduler_if #(.NUM_BTNS(5)) cmd_if ();
    button_scheduler_if #(.NUM_BTNS(5)) cmd_if0 ();

    button_scheduler #(.NUM_BTNS(5), .LOCKOUT_COUNT(4), .REPEAT_COUNT(6)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .cmd        (cmd_if),
        .busy       (busy),
        .cmdDropped (cmdDropped)
    );

    button_scheduler #(.NUM_BTNS(5), .LOCKOUT_COUNT(4), .REPEAT_COUNT(0)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .cmd        (cmd_if0),
        .busy       (busy0),
        .cmdDropped (cmdDropped0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int         cyc      = 0;
    int         n_acc    = 0;
    int         n_acc0   = 0;
    int         n_drop   = 0;
    int         last_acc = 0;
    int         acc_intv = 0;
    logic [2:0] last_id  = '0;
    logic [2:0] last_id0 = '0;
    int         a0, d0, b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && cmd_if.cmdValid && cmd_if.cmdReady) begin
            n_acc    <= n_acc + 1;
            acc_intv <= cyc - last_acc;
            last_acc <= cyc;
            last_id  <= cmd_if.cmdId;
        end
        if (!reset && cmd_if0.cmdValid && cmd_if0.cmdReady) begin
            n_acc0   <= n_acc0 + 1;
            last_id0 <= cmd_if0.cmdId;
        end
        if (!reset && cmdDropped) n_drop <= n_drop + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = '0;
        cmd_if.cmdReady  = 1'b1;
        cmd_if0.cmdReady = 1'b1;
        repeat (3) tick();
        chk("rst_valid",    32'(cmd_if.cmdValid), 32'd0);
        chk("rst_id",       32'(cmd_if.cmdId),    32'd0);
        chk("rst_busy",     32'(busy),            32'd0);
        chk("rst_drop",     32'(cmdDropped),      32'd0);
        chk("rst_busy0",    32'(busy0),           32'd0);
        chk("rst_drop0",    32'(cmdDropped0),     32'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_ready_no_cmd", 32'(n_acc), 32'd0);
        chk("idle_busy",         32'(busy),  32'd0);

        // Single press: visible two edges after sampling, accepted on the next.
        a0  = n_acc;
        btn = 5'b00100;
        tick();
        chk("s1_lat_k",   32'(cmd_if.cmdValid), 32'd0);
        tick();
        chk("s1_lat_k1",  32'(cmd_if.cmdValid), 32'd0);
        tick();
        chk("s1_valid",   32'(cmd_if.cmdValid), 32'd1);
        chk("s1_id",      32'(cmd_if.cmdId),    32'd2);
        tick();
        chk("s1_accept",  32'(cmd_if.cmdValid), 32'd0);
        chk("s1_acc_cnt", 32'(n_acc - a0),      32'd1);
        btn = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s1_lock_valid", 32'(cmd_if.cmdValid), 32'd0);
            chk("s1_lock_busy",  32'(busy),            32'd1);
        end
        tick();
        chk("s1_hold_busy", 32'(busy), 32'd1);
        tick();
        chk("s1_idle_busy", 32'(busy), 32'd0);

        // Backpressure: command holds steady until cmdReady rises.
        cmd_if.cmdReady = 1'b0;
        a0  = n_acc;
        btn = 5'b00100;
        repeat (3) tick();
        chk("s2_valid", 32'(cmd_if.cmdValid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s2_hold_valid", 32'(cmd_if.cmdValid), 32'd1);
            chk("s2_hold_id",    32'(cmd_if.cmdId),    32'd2);
        end
        chk("s2_no_acc", 32'(n_acc - a0), 32'd0);
        cmd_if.cmdReady = 1'b1;
        tick();
        chk("s2_accept",  32'(cmd_if.cmdValid), 32'd0);
        chk("s2_acc_cnt", 32'(n_acc - a0),      32'd1);
        btn = '0;
        repeat (8) tick();
        chk("s2_idle", 32'(busy), 32'd0);

        // Simultaneous press: lowest index wins, loser is not reported dropped.
        a0  = n_acc;
        d0  = n_drop;
        btn = 5'b10010;
        repeat (3) tick();
        chk("s3_valid", 32'(cmd_if.cmdValid), 32'd1);
        chk("s3_id",    32'(cmd_if.cmdId),    32'd1);
        tick();
        chk("s3_accept", 32'(cmd_if.cmdValid), 32'd0);
        btn = '0;
        repeat (8) tick();
        chk("s3_idle",    32'(busy),          32'd0);
        chk("s3_acc_cnt", 32'(n_acc - a0),    32'd1);
        chk("s3_no_drop", 32'(n_drop - d0),   32'd0);

        // Drop: button 0 pressed during lockout of button 3.
        a0  = n_acc;
        d0  = n_drop;
        btn = 5'b01000;
        repeat (3) tick();
        chk("s4_valid", 32'(cmd_if.cmdValid), 32'd1);
        chk("s4_id",    32'(cmd_if.cmdId),    32'd3);
        tick();
        chk("s4_accept", 32'(cmd_if.cmdValid), 32'd0);
        btn = 5'b01001;
        tick();
        chk("s4_drop_a1", 32'(cmdDropped), 32'd0);
        tick();
        chk("s4_drop_a2", 32'(cmdDropped), 32'd0);
        tick();
        chk("s4_drop_a3", 32'(cmdDropped), 32'd1);
        tick();
        chk("s4_drop_a4", 32'(cmdDropped), 32'd0);
        btn = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_no_cmd", 32'(cmd_if.cmdValid), 32'd0);
        end
        tick();
        chk("s4_idle",     32'(busy),        32'd0);
        chk("s4_acc_cnt",  32'(n_acc - a0),  32'd1);
        chk("s4_drop_cnt", 32'(n_drop - d0), 32'd1);
        btn = 5'b00001;
        repeat (3) tick();
        chk("s4_re_valid", 32'(cmd_if.cmdValid), 32'd1);
        chk("s4_re_id",    32'(cmd_if.cmdId),    32'd0);
        tick();
        btn = '0;
        repeat (8) tick();
        chk("s4_re_idle", 32'(busy), 32'd0);

        // Auto-repeat: every 11 cycles with repeat enabled, once without.
        a0  = n_acc;
        b0  = n_acc0;
        btn = 5'b10000;
        repeat (37) tick();
        chk("s5_acc_cnt",  32'(n_acc - a0),  32'd4);
        chk("s5_interval", 32'(acc_intv),    32'd11);
        chk("s5_id",       32'(last_id),     32'd4);
        chk("s5_norep",    32'(n_acc0 - b0), 32'd1);
        chk("s5_norep_id", 32'(last_id0),    32'd4);
        chk("s5_norep_hold", 32'(busy0),     32'd1);
        btn = '0;
        repeat (10) tick();
        chk("s5_idle",  32'(busy),  32'd0);
        chk("s5_idle0", 32'(busy0), 32'd0);

        // Asynchronous reset while a command is pending.
        cmd_if.cmdReady = 1'b0;
        btn = 5'b00100;
        repeat (3) tick();
        chk("s6_valid", 32'(cmd_if.cmdValid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_async_valid", 32'(cmd_if.cmdValid), 32'd0);
        chk("s6_async_busy",  32'(busy),            32'd0);
        chk("s6_async_id",    32'(cmd_if.cmdId),    32'd0);
        btn = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("s6_post_busy",  32'(busy),            32'd0);
        chk("s6_post_valid", 32'(cmd_if.cmdValid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
